ysyx_23060187_idu_q: RTL

Parametrised decode stage with an output queue. It sits between IFU and EXU and decodes each RV32I instruction, plus optional RV32M. Decoded fields are stored in a DEPTH-entry FIFO so IFU can keep fetching while EXU stalls. Both sides use a standard valid/ready handshake, and a flush input discards queued work on redirect.

---
 rtl/ysyx_23060187_idu_q.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060187_idu_q.sv
// ----------------------------------------------------------------------------
// ysyx_23060187_idu_q
// Decode stage between IFU and EXU. Each RV32I (optionally RV32M) instruction
// is decoded combinationally and the result is stored in a DEPTH-entry FIFO,
// so IFU can keep fetching while EXU stalls.
//
// Ports:
//   clk, rst       clock; synchronous active-low reset
//   flush          drop every queued entry and any same-cycle input
//   in_valid/in_ready, in_inst, in_pc       IFU side (valid/ready)
//   out_valid/out_ready                     EXU side (valid/ready)
//   out_pc, out_inst, out_imm               head entry data
//   out_rs1, out_rs2, out_rd, out_fun3      fields of the head instruction
//   out_class      one-hot {illegal,system,muldiv,store,load,jump,branch,alu}
//   out_wen        rd write enable
//   count          queue occupancy
// All out_* data fields read zero while out_valid is low.
// ----------------------------------------------------------------------------
module ysyx_23060187_idu_q #(
  parameter int unsigned DEPTH    = 2,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned PC_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_inst,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic [31:0]                  out_inst,
  output logic [31:0]                  out_imm,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [4:0]                   out_rd,
  output logic [2:0]                   out_fun3,
  output logic [7:0]                   out_class,
  output logic                         out_wen,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [7:0] CLS_ALU    = 8'h01;
  localparam logic [7:0] CLS_BRANCH = 8'h02;
  localparam logic [7:0] CLS_JUMP   = 8'h04;
  localparam logic [7:0] CLS_LOAD   = 8'h08;
  localparam logic [7:0] CLS_STORE  = 8'h10;
  localparam logic [7:0] CLS_MULDIV = 8'h20;
  localparam logic [7:0] CLS_SYSTEM = 8'h40;
  localparam logic [7:0] CLS_ILL    = 8'h80;
  // Classes that write rd: alu, jump, load, muldiv
  localparam logic [7:0] WEN_MASK   = 8'h2D;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // Decode results
  logic [6:0]  opc_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [31:0] dec_imm_s;
  logic [7:0]  dec_cls_s;
  logic        dec_ill_s;
  logic        dec_wen_s;

  // FIFO state
  logic [PC_W-1:0] pc_mem_q   [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     imm_mem_q  [DEPTH];
  logic [7:0]      cls_mem_q  [DEPTH];
  logic            wen_mem_q  [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_s;
  logic            pop_s;
  logic [31:0]     head_inst_s;

  assign opc_s = in_inst[6:0];
  assign f3_s  = in_inst[14:12];
  assign f7_s  = in_inst[31:25];

  // Instruction decode: immediate, class and legality
  always_comb begin
    dec_imm_s = 32'h0000_0000;
    dec_cls_s = 8'h00;
    dec_ill_s = 1'b0;
    case (opc_s)
      OPC_LUI, OPC_AUIPC: begin
        dec_imm_s = {in_inst[31:12], 12'h000};
        dec_cls_s = CLS_ALU;
      end
      OPC_JAL: begin
        dec_imm_s = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                     in_inst[20], in_inst[30:21], 1'b0};
        dec_cls_s = CLS_JUMP;
      end
      OPC_JALR: begin
        dec_imm_s = {{20{in_inst[31]}}, in_inst[31:20]};
        dec_cls_s = CLS_JUMP;
        dec_ill_s = (f3_s != 3'b000);
      end
      OPC_BRANCH: begin
        dec_imm_s = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                     in_inst[30:25], in_inst[11:8], 1'b0};
        dec_cls_s = CLS_BRANCH;
        dec_ill_s = (f3_s == 3'b010) || (f3_s == 3'b011);
      end
      OPC_LOAD: begin
        dec_imm_s = {{20{in_inst[31]}}, in_inst[31:20]};
        dec_cls_s = CLS_LOAD;
        dec_ill_s = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
      end
      OPC_STORE: begin
        dec_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        dec_cls_s = CLS_STORE;
        dec_ill_s = (f3_s >= 3'b011);
      end
      OPC_OPIMM: begin
        dec_imm_s = {{20{in_inst[31]}}, in_inst[31:20]};
        dec_cls_s = CLS_ALU;
        // Shift-immediates reuse the upper immediate bits as a funct7 field
        if (f3_s == 3'b001) begin
          dec_ill_s = (f7_s != F7_ZERO);
        end else if (f3_s == 3'b101) begin
          dec_ill_s = (f7_s != F7_ZERO) && (f7_s != F7_ALT);
        end else begin
          dec_ill_s = 1'b0;
        end
      end
      OPC_OP: begin
        if (f7_s == F7_ZERO) begin
          dec_cls_s = CLS_ALU;
        end else if (f7_s == F7_MUL) begin
          dec_cls_s = CLS_MULDIV;
          dec_ill_s = !ENABLE_M;
        end else if (f7_s == F7_ALT) begin
          // Only sub and sra use the alternate funct7
          dec_cls_s = CLS_ALU;
          dec_ill_s = (f3_s != 3'b000) && (f3_s != 3'b101);
        end else begin
          dec_ill_s = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        dec_imm_s = {{20{in_inst[31]}}, in_inst[31:20]};
        dec_cls_s = CLS_SYSTEM;
      end
      default: begin
        dec_ill_s = 1'b1;
      end
    endcase
    if (dec_ill_s) begin
      dec_cls_s = CLS_ILL;
    end else begin
      dec_cls_s = dec_cls_s;
    end
  end

  assign dec_wen_s = (|(dec_cls_s & WEN_MASK)) && (in_inst[11:7] != 5'd0);

  // Handshake; a full queue refuses input even if EXU pops this cycle
  assign in_ready  = rst && (count_q < CW'(DEPTH));
  assign out_valid = (count_q != {CW{1'b0}});
  assign push_s    = in_valid && in_ready && !flush;
  assign pop_s     = out_valid && out_ready && !flush;
  assign count     = count_q;

  // Pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: reset beats flush beats push/pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only visible through out_valid, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_q[wr_ptr_q]   <= in_pc;
      inst_mem_q[wr_ptr_q] <= in_inst;
      imm_mem_q[wr_ptr_q]  <= dec_imm_s;
      cls_mem_q[wr_ptr_q]  <= dec_cls_s;
      wen_mem_q[wr_ptr_q]  <= dec_wen_s;
    end
  end

  assign head_inst_s = inst_mem_q[rd_ptr_q];

  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]  : {PC_W{1'b0}};
  assign out_inst  = out_valid ? head_inst_s         : 32'h0000_0000;
  assign out_imm   = out_valid ? imm_mem_q[rd_ptr_q] : 32'h0000_0000;
  assign out_class = out_valid ? cls_mem_q[rd_ptr_q] : 8'h00;
  assign out_wen   = out_valid ? wen_mem_q[rd_ptr_q] : 1'b0;
  assign out_rs1   = out_valid ? head_inst_s[19:15]  : 5'd0;
  assign out_rs2   = out_valid ? head_inst_s[24:20]  : 5'd0;
  assign out_rd    = out_valid ? head_inst_s[11:7]   : 5'd0;
  assign out_fun3  = out_valid ? head_inst_s[14:12]  : 3'd0;

endmodule
